ram_march_bist: RTL and testbench

//  Built-in self-test initiator for the 8x8 single-port RAM; drives its data/addr/we port and checks q.

---
 rtl/ram_march_bist.sv | 205 ++++++++++++++++++++
 tb/tb_ram_march_bist.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// ram_march_bist: March C- built-in self-test initiator for the 8x8 single-port RAM.
// Drives the RAM data/addr/we port, checks q, reports pass/fail with the first
// failing address and the expected-XOR-observed bit mask.
// Optional feature macro: BIST_CHECKERBOARD_EN -- when defined, the solid-background
// pass (0x00/0xFF) is followed by a second pass with background 0x55/0xAA.
module ram_march_bist #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int unsigned       DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] SOLID_BG  = '0;
   localparam logic [DATA_W-1:0] CHECK_BG  = {(DATA_W / 2){2'b01}};

`ifdef BIST_CHECKERBOARD_EN
   localparam bit CB_EN = 1'b1;
`else
   localparam bit CB_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // March C- elements in execution order
   typedef enum logic [2:0] {
      EL_W0,    // up   (wB)
      EL_R0W1,  // up   (rB,  w~B)
      EL_R1W0,  // up   (r~B, wB)
      EL_DR0W1, // down (rB,  w~B)
      EL_DR1W0, // down (r~B, wB)
      EL_R0     // up   (rB)
   } elem_t;

   state_t state;
   elem_t  elem;
   logic   second_phase;   // 0: RD cycle, 1: RW or CMP cycle of the current address
   logic   cb_pass;        // running the checkerboard background pass

   logic [DATA_W-1:0] bg_c;
   logic [DATA_W-1:0] wr_pat_c;
   logic [DATA_W-1:0] rd_exp_c;
   logic              down_c;
   logic              term_c;
   logic [ADDR_W-1:0] step_addr_c;
   elem_t             next_elem_c;
   logic [ADDR_W-1:0] next_first_c;
   logic              mismatch_c;

   // Pattern selection, address stepping and the read compare for the current element
   always_comb begin
      bg_c         = cb_pass ? CHECK_BG : SOLID_BG;
      wr_pat_c     = bg_c;
      rd_exp_c     = bg_c;
      down_c       = 1'b0;
      next_elem_c  = EL_W0;
      next_first_c = '0;

      case (elem)
         EL_W0:    begin wr_pat_c = bg_c;  rd_exp_c = bg_c;  next_elem_c = EL_R0W1;  end
         EL_R0W1:  begin wr_pat_c = ~bg_c; rd_exp_c = bg_c;  next_elem_c = EL_R1W0;  end
         EL_R1W0:  begin wr_pat_c = bg_c;  rd_exp_c = ~bg_c; next_elem_c = EL_DR0W1;
                         next_first_c = LAST_ADDR; end
         EL_DR0W1: begin wr_pat_c = ~bg_c; rd_exp_c = bg_c;  next_elem_c = EL_DR1W0;
                         next_first_c = LAST_ADDR; down_c = 1'b1; end
         EL_DR1W0: begin wr_pat_c = bg_c;  rd_exp_c = ~bg_c; next_elem_c = EL_R0;
                         down_c = 1'b1; end
         EL_R0:    begin wr_pat_c = '0;    rd_exp_c = bg_c;  next_elem_c = EL_W0;    end
         default:  begin wr_pat_c = '0;    rd_exp_c = '0;    next_elem_c = EL_W0;    end
      endcase

      term_c      = down_c ? (ram_addr == '0) : (ram_addr == LAST_ADDR);
      step_addr_c = down_c ? (ram_addr - ADDR_W'(1)) : (ram_addr + ADDR_W'(1));
      mismatch_c  = (ram_q != rd_exp_c);
   end

   // Run sequencer: start handling, March element walk, compare/abort and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         elem         <= EL_W0;
         second_phase <= 1'b0;
         cb_pass      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         fail_addr    <= '0;
         fail_data    <= '0;
         ram_data     <= '0;
         ram_addr     <= '0;
         ram_we       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done     <= 1'b0;
               ram_we   <= 1'b0;
               ram_addr <= '0;
               ram_data <= '0;
               if (start) begin
                  // first busy cycle is the E0 write of address 0
                  state        <= ST_RUN;
                  busy         <= 1'b1;
                  pass         <= 1'b0;
                  fail_addr    <= '0;
                  fail_data    <= '0;
                  elem         <= EL_W0;
                  second_phase <= 1'b0;
                  cb_pass      <= 1'b0;
                  ram_we       <= 1'b1;
                  ram_addr     <= '0;
                  ram_data     <= SOLID_BG;
               end
            end

            ST_RUN: begin
               if (elem == EL_W0) begin
                  if (term_c) begin
                     elem         <= next_elem_c;
                     second_phase <= 1'b0;
                     ram_we       <= 1'b0;
                     ram_addr     <= next_first_c;
                     ram_data     <= '0;
                  end else begin
                     ram_addr <= step_addr_c;
                     ram_data <= wr_pat_c;
                  end
               end else if (!second_phase) begin
                  // RD issued this cycle; follow with RW (same address) or CMP for E5
                  second_phase <= 1'b1;
                  ram_we       <= (elem != EL_R0);
                  ram_data     <= (elem != EL_R0) ? wr_pat_c : '0;
               end else if (mismatch_c) begin
                  // the write of this RW cycle still lands; only the first mismatch is kept
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  fail_addr <= ram_addr;
                  fail_data <= rd_exp_c ^ ram_q;
                  ram_we    <= 1'b0;
                  ram_addr  <= '0;
                  ram_data  <= '0;
               end else if (!term_c) begin
                  second_phase <= 1'b0;
                  ram_we       <= 1'b0;
                  ram_addr     <= step_addr_c;
                  ram_data     <= '0;
               end else if (elem != EL_R0) begin
                  elem         <= next_elem_c;
                  second_phase <= 1'b0;
                  ram_we       <= 1'b0;
                  ram_addr     <= next_first_c;
                  ram_data     <= '0;
               end else if (CB_EN && !cb_pass) begin
                  // solid pass clean: restart the march on the checkerboard background
                  cb_pass      <= 1'b1;
                  elem         <= EL_W0;
                  second_phase <= 1'b0;
                  ram_we       <= 1'b1;
                  ram_addr     <= '0;
                  ram_data     <= CHECK_BG;
               end else begin
                  state    <= ST_DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= 1'b1;
                  ram_we   <= 1'b0;
                  ram_addr <= '0;
                  ram_data <= '0;
               end
            end

            ST_DONE: begin
               // start is ignored during the done cycle
               state <= ST_IDLE;
               done  <= 1'b0;
            end

            default: begin
               state  <= ST_IDLE;
               busy   <= 1'b0;
               done   <= 1'b0;
               ram_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_march_bist.sv
// tb_ram_march_bist: directed + randomized-fault bench for ram_march_bist.
// Honours BIST_CHECKERBOARD_EN the same way as the design.
module tb_ram_march_bist;

   localparam int DEPTH = 8;

`ifdef BIST_CHECKERBOARD_EN
   localparam bit CB = 1'b1;
`else
   localparam bit CB = 1'b0;
`endif

   typedef struct packed {
      logic       we;
      logic [2:0] addr;
      logic [7:0] data;
   } op_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       busy, done, pass;
   logic [2:0] fail_addr;
   logic [7:0] fail_data;
   logic [7:0] ram_data;
   logic [2:0] ram_addr;
   logic       ram_we;
   logic [7:0] ram_q;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ram_march_bist #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .fail_addr(fail_addr),
      .fail_data(fail_data),
      .ram_data (ram_data),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_q    (ram_q)
   );

   // Behavioural RAM with per-address stuck-at masks
   logic [7:0] mem [DEPTH];
   logic [2:0] lat_addr;
   logic [7:0] sa0 [DEPTH];
   logic [7:0] sa1 [DEPTH];

   function automatic logic [7:0] faulty(input logic [7:0] d, input int a);
      return (d & ~sa0[a]) | sa1[a];
   endfunction

   assign ram_q = mem[lat_addr];

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= faulty(ram_data, int'(ram_addr));
      else        lat_addr      <= ram_addr;
   end

   // Reference: expected per-busy-cycle RAM operations and outcome of one run
   op_t        exp_ops[$];
   int         exp_writes;
   logic       exp_pass;
   logic [2:0] exp_faddr;
   logic [7:0] exp_fdata;

   task automatic build_ref();
      logic [7:0] rm [DEPTH];
      logic [7:0] bgp, rdv, wrv, obs;
      bit down, has_wr;
      int a;
      exp_ops.delete();
      exp_writes = 0;
      exp_pass   = 1'b1;
      exp_faddr  = '0;
      exp_fdata  = '0;
      for (int p = 0; p < (CB ? 2 : 1); p++) begin
         bgp = (p == 1) ? 8'h55 : 8'h00;
         for (int k = 0; k < DEPTH; k++) begin
            rm[k] = faulty(bgp, k);
            exp_ops.push_back('{1'b1, 3'(k), bgp});
            exp_writes++;
         end
         for (int e = 1; e <= 5; e++) begin
            down   = (e == 3) || (e == 4);
            has_wr = (e != 5);
            rdv    = (e % 2 == 1) ? bgp : ~bgp;
            wrv    = (e % 2 == 1) ? ~bgp : bgp;
            for (int k = 0; k < DEPTH; k++) begin
               a = down ? (DEPTH - 1 - k) : k;
               exp_ops.push_back('{1'b0, 3'(a), 8'h00});
               obs = rm[a];
               if (has_wr) begin
                  rm[a] = faulty(wrv, a);
                  exp_ops.push_back('{1'b1, 3'(a), wrv});
                  exp_writes++;
               end else begin
                  exp_ops.push_back('{1'b0, 3'(a), 8'h00});
               end
               if (obs != rdv) begin
                  exp_pass  = 1'b0;
                  exp_faddr = 3'(a);
                  exp_fdata = obs ^ rdv;
                  return;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < DEPTH; i++) begin
         sa0[i] = 8'h00;
         sa1[i] = 8'h00;
      end
   endtask

   // Start a run at a falling edge, follow every busy cycle, then check the result
   task automatic run_check(input string tag, input bit hold, output int cyc);
      int  wr;
      op_t obs_op, eop;
      cyc = 0;
      wr  = 0;
      build_ref();
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      while (busy === 1'b1 && cyc < 400) begin
         obs_op = '{ram_we, ram_addr, (ram_we ? ram_data : 8'h00)};
         eop    = (cyc < exp_ops.size()) ? exp_ops[cyc] : op_t'(12'hfff);
         chk($sformatf("%s op[%0d]", tag, cyc), 32'(obs_op), 32'(eop));
         if (ram_we) wr++;
         cyc++;
         @(negedge clk);
      end
      chk({tag, " busy_cycles"}, 32'(cyc), 32'(exp_ops.size()));
      chk({tag, " writes"},      32'(wr), 32'(exp_writes));
      chk({tag, " done"},        32'(done), 32'(1));
      chk({tag, " pass"},        32'(pass), 32'(exp_pass));
      chk({tag, " fail_addr"},   32'(fail_addr), 32'(exp_faddr));
      chk({tag, " fail_data"},   32'(fail_data), 32'(exp_fdata));
      @(negedge clk);
      chk({tag, " idle_done"},   32'(done), 32'(0));
      chk({tag, " idle_busy"},   32'(busy), 32'(0));
      chk({tag, " idle_we"},     32'(ram_we), 32'(0));
      chk({tag, " pass_held"},   32'(pass), 32'(exp_pass));
   endtask

   initial begin
      int cyc;
      int fa, fb;
      rst_n = 1'b0;
      start = 1'b0;
      clear_faults();
      repeat (3) @(negedge clk);
      chk("rst busy",      32'(busy), 32'(0));
      chk("rst done",      32'(done), 32'(0));
      chk("rst pass",      32'(pass), 32'(0));
      chk("rst we",        32'(ram_we), 32'(0));
      chk("rst addr",      32'(ram_addr), 32'(0));
      chk("rst data",      32'(ram_data), 32'(0));
      chk("rst fail_addr", 32'(fail_addr), 32'(0));
      chk("rst fail_data", 32'(fail_data), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // fault-free run
      run_check("clean", 1'b0, cyc);
      chk("clean length", 32'(cyc), CB ? 32'd176 : 32'd88);

      // bit0 stuck-at-1 at address 5: caught in E1 RW at busy cycle 19
      sa1[5] = 8'h01;
      run_check("sa1_a5", 1'b0, cyc);
      chk("sa1_a5 length",    32'(cyc), 32'd20);
      chk("sa1_a5 fail_addr", 32'(fail_addr), 32'd5);
      chk("sa1_a5 fail_data", 32'(fail_data), 32'h01);
      clear_faults();

      // start held high: one full run, one idle cycle, then the next run
      run_check("hold", 1'b1, cyc);
      run_check("after_hold", 1'b0, cyc);

      // random single stuck-at faults
      for (int n = 0; n < 6; n++) begin
         fa = int'($urandom_range(0, DEPTH - 1));
         fb = int'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) sa1[fa] = 8'(1 << fb);
         else                           sa0[fa] = 8'(1 << fb);
         run_check($sformatf("rand%0d", n), 1'b0, cyc);
         clear_faults();
      end

      // random pair of faults on different addresses; only the first is reported
      fa = int'($urandom_range(0, DEPTH - 1));
      sa0[fa] = 8'(1 << $urandom_range(0, 7));
      sa1[(fa + 3) % DEPTH] = 8'(1 << $urandom_range(0, 7));
      run_check("pair", 1'b0, cyc);
      clear_faults();

      // asynchronous reset at busy cycle 40
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("pre_rst busy", 32'(busy), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst we",   32'(ram_we), 32'(0));
      chk("mid_rst busy", 32'(busy), 32'(0));
      chk("mid_rst pass", 32'(pass), 32'(0));
      chk("mid_rst done", 32'(done), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_check("post_rst", 1'b0, cyc);
      chk("post_rst length", 32'(cyc), CB ? 32'd176 : 32'd88);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
